// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM pipeline stage: access sizes, FSM states and
// the byte-mask helper used by both the load and store lane logic.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int unsigned CNT_W = 32;

  // Unshifted byte-enable pattern for an access size; encoding 11 behaves as word.
  function automatic logic [3:0] size_mask(input mem_size_e sz);
    logic [3:0] m;
    case (sz)
      SZ_BYTE: m = 4'b0001;
      SZ_HALF: m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Lane logic for data memory accesses: byte enables, store replication,
// misalignment detection and load lane extraction with sign/zero extension.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  mem_size_e   size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  logic [31:0] shifted_s;

  // Byte enables, store replication and alignment check per access size.
  always_comb begin
    be_o       = size_mask(size_i) << addr_lo_i;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        wdata_o    = {4{wdata_i[7:0]}};
        misalign_o = 1'b0;
      end
      SZ_HALF: begin
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      default: begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        misalign_o = (addr_lo_i != 2'b00);
      end
    endcase
  end

  // Move the addressed lane down to bit 0, then extend to a full word.
  always_comb begin
    shifted_s = rdata_i >> {addr_lo_i, 3'b000};
    load_o    = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        if (signed_i) begin
          load_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
        end else begin
          load_o = {24'd0, shifted_s[7:0]};
        end
      end
      SZ_HALF: begin
        if (signed_i) begin
          load_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
        end else begin
          load_o = {16'd0, shifted_s[15:0]};
        end
      end
      default: load_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over a req/ack data-memory port,
// stalls upstream while an access is outstanding and feeds the MEM/WB register.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead_In,
  input  logic        MemWrite_In,
  input  logic [1:0]  MemSize_In,
  input  logic        MemSigned_In,
  input  logic        RegWrite_In,
  input  logic        MemToReg_In,
  input  logic [31:0] ALU_Result_In,
  input  logic [31:0] WriteData_In,
  input  logic [31:0] PC_AddResult_In,
  input  logic [4:0]  EX_MEM_Rd_In,
  output logic        DM_Req,
  output logic        DM_We,
  output logic [31:0] DM_Addr,
  output logic [3:0]  DM_BE,
  output logic [31:0] DM_WData,
  input  logic [31:0] DM_RData,
  input  logic        DM_Ack,
  output logic        Stall,
  output logic        RegWrite_Out,
  output logic        MemToReg_Out,
  output logic [31:0] DM_ReadData_Out,
  output logic [31:0] ALU_Result_Out,
  output logic [31:0] PC_AddResult_Out,
  output logic [4:0]  Rd_Out,
  output logic        MisalignErr,
  output logic        BusErr
);

  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LIMIT =
    (TIMEOUT_CYCLES == 0) ? 32'd0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               abort_q, abort_d;

  logic               mem_op_s;
  logic               is_load_s;
  logic               misalign_s;
  logic               access_s;
  logic               req_s;
  logic               done_s;
  logic               mis_err_s;
  logic [31:0]        load_s;
  logic [3:0]         be_s;
  logic [31:0]        wdata_s;

  assign mem_op_s  = MemRead_In | MemWrite_In;
  assign is_load_s = MemRead_In & ~MemWrite_In;
  assign access_s  = mem_op_s & ~misalign_s;

  mem_load_align u_align (
    .size_i     (mem_size_e'(MemSize_In)),
    .signed_i   (MemSigned_In),
    .addr_lo_i  (ALU_Result_In[1:0]),
    .rdata_i    (rdata_q),
    .wdata_i    (WriteData_In),
    .load_o     (load_s),
    .be_o       (be_s),
    .wdata_o    (wdata_s),
    .misalign_o (misalign_s)
  );

  // Next-state, timeout counter and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    abort_d = abort_q;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
        if (access_s) begin
          if (DM_Ack) begin
            state_d = ST_DONE;
            rdata_d = DM_RData;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (DM_Ack) begin
          state_d = ST_DONE;
          rdata_d = DM_RData;
        end else if (TIMEOUT_EN && (cnt_q >= TO_LIMIT)) begin
          state_d = ST_DONE;
          abort_d = 1'b1;
          rdata_d = 32'd0;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        rdata_d = 32'd0;
        abort_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      rdata_q <= 32'd0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
    end
  end

  // Request/done decode from the current state.
  always_comb begin
    req_s  = 1'b0;
    done_s = 1'b0;
    case (state_q)
      ST_IDLE: req_s  = access_s;
      ST_WAIT: req_s  = 1'b1;
      ST_DONE: done_s = 1'b1;
      default: begin
        req_s  = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  assign mis_err_s = (state_q == ST_IDLE) & mem_op_s & misalign_s;

  // Memory port, stall and writeback outputs; reset forces every output low.
  always_comb begin
    DM_Req           = 1'b0;
    DM_We            = 1'b0;
    DM_Addr          = 32'd0;
    DM_BE            = 4'b0000;
    DM_WData         = 32'd0;
    Stall            = 1'b0;
    RegWrite_Out     = 1'b0;
    MemToReg_Out     = 1'b0;
    DM_ReadData_Out  = 32'd0;
    ALU_Result_Out   = 32'd0;
    PC_AddResult_Out = 32'd0;
    Rd_Out           = 5'd0;
    MisalignErr      = 1'b0;
    BusErr           = 1'b0;
    if (Rst) begin
      DM_Req           = req_s;
      Stall            = req_s;
      MisalignErr      = mis_err_s;
      BusErr           = done_s & abort_q;
      RegWrite_Out     = RegWrite_In & ~req_s & ~mis_err_s & ~(done_s & abort_q);
      MemToReg_Out     = MemToReg_In;
      ALU_Result_Out   = ALU_Result_In;
      PC_AddResult_Out = PC_AddResult_In;
      Rd_Out           = EX_MEM_Rd_In;
      if (req_s) begin
        DM_We    = MemWrite_In;
        DM_Addr  = {ALU_Result_In[31:2], 2'b00};
        DM_BE    = be_s;
        DM_WData = wdata_s;
      end else begin
        DM_We    = 1'b0;
        DM_Addr  = 32'd0;
        DM_BE    = 4'b0000;
        DM_WData = 32'd0;
      end
      if (done_s && !abort_q && is_load_s) begin
        DM_ReadData_Out = load_s;
      end else begin
        DM_ReadData_Out = 32'd0;
      end
    end else begin
      DM_Req = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a per-cycle vector table fed
// through an expected-value queue, plus reset and mid-access reset sequences.
module tb_mem_access_stage;

  logic        Clk;
  logic        Rst;
  logic        MemRead_In, MemWrite_In, MemSigned_In, RegWrite_In, MemToReg_In;
  logic [1:0]  MemSize_In;
  logic [31:0] ALU_Result_In, WriteData_In, PC_AddResult_In, DM_RData;
  logic [4:0]  EX_MEM_Rd_In;
  logic        DM_Ack;
  logic        DM_Req, DM_We, Stall, RegWrite_Out, MemToReg_Out, MisalignErr, BusErr;
  logic [31:0] DM_Addr, DM_WData, DM_ReadData_Out, ALU_Result_Out, PC_AddResult_Out;
  logic [3:0]  DM_BE;
  logic [4:0]  Rd_Out;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In), .MemSize_In(MemSize_In),
    .MemSigned_In(MemSigned_In), .RegWrite_In(RegWrite_In), .MemToReg_In(MemToReg_In),
    .ALU_Result_In(ALU_Result_In), .WriteData_In(WriteData_In),
    .PC_AddResult_In(PC_AddResult_In), .EX_MEM_Rd_In(EX_MEM_Rd_In),
    .DM_Req(DM_Req), .DM_We(DM_We), .DM_Addr(DM_Addr), .DM_BE(DM_BE),
    .DM_WData(DM_WData), .DM_RData(DM_RData), .DM_Ack(DM_Ack), .Stall(Stall),
    .RegWrite_Out(RegWrite_Out), .MemToReg_Out(MemToReg_Out),
    .DM_ReadData_Out(DM_ReadData_Out), .ALU_Result_Out(ALU_Result_Out),
    .PC_AddResult_Out(PC_AddResult_Out), .Rd_Out(Rd_Out),
    .MisalignErr(MisalignErr), .BusErr(BusErr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [1:0]  sz;
    logic        sgn, rw;
    logic [31:0] alu, wd;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        e_stall, e_req, e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_rw;
    logic [31:0] e_rdo;
    logic        e_mis, e_bus;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs[NV];
  vec_t exp_q[$];

  function automatic vec_t mk(input string nm, input logic rd, input logic wr,
                              input logic [1:0] sz, input logic sgn, input logic rw,
                              input logic [31:0] alu, input logic [31:0] wd,
                              input logic ack, input logic [31:0] rdata,
                              input logic es, input logic er, input logic ew,
                              input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic erw,
                              input logic [31:0] erdo, input logic emis, input logic ebus);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.sz = sz; v.sgn = sgn; v.rw = rw;
    v.alu = alu; v.wd = wd; v.ack = ack; v.rdata = rdata; v.pc = alu + 32'h0040_0000;
    v.e_stall = es; v.e_req = er; v.e_we = ew; v.e_addr = ea; v.e_be = ebe;
    v.e_wdata = ewd; v.e_rw = erw; v.e_rdo = erdo; v.e_mis = emis; v.e_bus = ebus;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    MemRead_In = v.rd; MemWrite_In = v.wr; MemSize_In = v.sz; MemSigned_In = v.sgn;
    RegWrite_In = v.rw; MemToReg_In = v.rd; ALU_Result_In = v.alu;
    WriteData_In = v.wd; PC_AddResult_In = v.pc; EX_MEM_Rd_In = 5'd5;
    DM_Ack = v.ack; DM_RData = v.rdata;
  endtask

  task automatic compare_row(input vec_t v);
    chk({v.name, ".stall"}, 32'(Stall), 32'(v.e_stall));
    chk({v.name, ".req"}, 32'(DM_Req), 32'(v.e_req));
    chk({v.name, ".regwrite"}, 32'(RegWrite_Out), 32'(v.e_rw));
    chk({v.name, ".rdata_out"}, DM_ReadData_Out, v.e_rdo);
    chk({v.name, ".misalign"}, 32'(MisalignErr), 32'(v.e_mis));
    chk({v.name, ".buserr"}, 32'(BusErr), 32'(v.e_bus));
    chk({v.name, ".memtoreg"}, 32'(MemToReg_Out), 32'(v.rd));
    chk({v.name, ".alu_out"}, ALU_Result_Out, v.alu);
    chk({v.name, ".pc_out"}, PC_AddResult_Out, v.pc);
    chk({v.name, ".rd_out"}, 32'(Rd_Out), 32'd5);
    if (v.e_req) begin
      chk({v.name, ".we"}, 32'(DM_We), 32'(v.e_we));
      chk({v.name, ".addr"}, DM_Addr, v.e_addr);
      chk({v.name, ".be"}, 32'(DM_BE), 32'(v.e_be));
      if (v.e_we) begin
        chk({v.name, ".wdata"}, DM_WData, v.e_wdata);
      end
    end
  endtask

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  initial begin
    vec_t e;
    //            name         rd wr sz     sg rw alu           wd            ack rdata          st req we addr          be       wdata         rw rdo           mis bus
    vecs[0]  = mk("alu_pass",  N, N, 2'b00, N, Y, 32'h0000_1234, 32'h0,       N, 32'h0,          N, N, N, 32'h0,        4'b0000, 32'h0,        Y, 32'h0,        N, N);
    vecs[1]  = mk("alu_pass2", N, N, 2'b10, N, Y, 32'hDEAD_BEEF, 32'h0,       N, 32'h0,          N, N, N, 32'h0,        4'b0000, 32'h0,        Y, 32'h0,        N, N);
    vecs[2]  = mk("no_wb",     N, N, 2'b00, N, N, 32'h0000_0055, 32'h0,       N, 32'h0,          N, N, N, 32'h0,        4'b0000, 32'h0,        N, 32'h0,        N, N);
    vecs[3]  = mk("lb_c1",     Y, N, 2'b00, Y, Y, 32'h0000_0103, 32'h0,       N, 32'h0,          Y, Y, N, 32'h100,      4'b1000, 32'h0,        N, 32'h0,        N, N);
    vecs[4]  = mk("lb_c2",     Y, N, 2'b00, Y, Y, 32'h0000_0103, 32'h0,       N, 32'h0,          Y, Y, N, 32'h100,      4'b1000, 32'h0,        N, 32'h0,        N, N);
    vecs[5]  = mk("lb_c3",     Y, N, 2'b00, Y, Y, 32'h0000_0103, 32'h0,       Y, 32'h80FF_FF7F,  Y, Y, N, 32'h100,      4'b1000, 32'h0,        N, 32'h0,        N, N);
    vecs[6]  = mk("lb_done",   Y, N, 2'b00, Y, Y, 32'h0000_0103, 32'h0,       N, 32'h0,          N, N, N, 32'h0,        4'b0000, 32'h0,        Y, 32'hFFFF_FF80, N, N);
    vecs[7]  = mk("lbu_c1",    Y, N, 2'b00, N, Y, 32'h0000_0103, 32'h0,       N, 32'h0,          Y, Y, N, 32'h100,      4'b1000, 32'h0,        N, 32'h0,        N, N);
    vecs[8]  = mk("lbu_c2",    Y, N, 2'b00, N, Y, 32'h0000_0103, 32'h0,       N, 32'h0,          Y, Y, N, 32'h100,      4'b1000, 32'h0,        N, 32'h0,        N, N);
    vecs[9]  = mk("lbu_c3",    Y, N, 2'b00, N, Y, 32'h0000_0103, 32'h0,       Y, 32'h80FF_FF7F,  Y, Y, N, 32'h100,      4'b1000, 32'h0,        N, 32'h0,        N, N);
    vecs[10] = mk("lbu_done",  Y, N, 2'b00, N, Y, 32'h0000_0103, 32'h0,       N, 32'h0,          N, N, N, 32'h0,        4'b0000, 32'h0,        Y, 32'h0000_0080, N, N);
    vecs[11] = mk("sh_req",    N, Y, 2'b01, N, N, 32'h0000_0202, 32'hAAAA_BEEF, Y, 32'h0,        Y, Y, Y, 32'h200,      4'b1100, 32'hBEEF_BEEF, N, 32'h0,        N, N);
    vecs[12] = mk("sh_done",   N, Y, 2'b01, N, N, 32'h0000_0202, 32'hAAAA_BEEF, N, 32'h0,        N, N, N, 32'h0,        4'b0000, 32'h0,        N, 32'h0,        N, N);
    vecs[13] = mk("sh_next",   N, N, 2'b00, N, Y, 32'h0000_0099, 32'h0,       N, 32'h0,          N, N, N, 32'h0,        4'b0000, 32'h0,        Y, 32'h0,        N, N);
    vecs[14] = mk("lh_req",    Y, N, 2'b01, Y, Y, 32'h0000_0102, 32'h0,       Y, 32'h8001_7FFF,  Y, Y, N, 32'h100,      4'b1100, 32'h0,        N, 32'h0,        N, N);
    vecs[15] = mk("lh_done",   Y, N, 2'b01, Y, Y, 32'h0000_0102, 32'h0,       N, 32'h0,          N, N, N, 32'h0,        4'b0000, 32'h0,        Y, 32'hFFFF_8001, N, N);
    vecs[16] = mk("sb_req",    N, Y, 2'b00, N, N, 32'h0000_0201, 32'h0000_0012, Y, 32'h0,        Y, Y, Y, 32'h200,      4'b0010, 32'h1212_1212, N, 32'h0,        N, N);
    vecs[17] = mk("sb_done",   N, Y, 2'b00, N, N, 32'h0000_0201, 32'h0000_0012, N, 32'h0,        N, N, N, 32'h0,        4'b0000, 32'h0,        N, 32'h0,        N, N);
    vecs[18] = mk("lw_req",    Y, N, 2'b10, N, Y, 32'h0000_0044, 32'h0,       Y, 32'hCAFE_F00D,  Y, Y, N, 32'h44,       4'b1111, 32'h0,        N, 32'h0,        N, N);
    vecs[19] = mk("lw_done",   Y, N, 2'b10, N, Y, 32'h0000_0044, 32'h0,       N, 32'h0,          N, N, N, 32'h0,        4'b0000, 32'h0,        Y, 32'hCAFE_F00D, N, N);
    vecs[20] = mk("lw_mis",    Y, N, 2'b10, N, Y, 32'h0000_0101, 32'h0,       N, 32'h0,          N, N, N, 32'h0,        4'b0000, 32'h0,        N, 32'h0,        Y, N);
    vecs[21] = mk("mis_next",  N, N, 2'b00, N, Y, 32'h0000_0101, 32'h0,       N, 32'h0,          N, N, N, 32'h0,        4'b0000, 32'h0,        Y, 32'h0,        N, N);
    vecs[22] = mk("sh_mis",    N, Y, 2'b01, N, N, 32'h0000_0203, 32'h1234_5678, N, 32'h0,        N, N, N, 32'h0,        4'b0000, 32'h0,        N, 32'h0,        Y, N);
    vecs[23] = mk("sz11_req",  Y, N, 2'b11, N, Y, 32'h0000_0048, 32'h0,       Y, 32'h1234_5678,  Y, Y, N, 32'h48,       4'b1111, 32'h0,        N, 32'h0,        N, N);
    vecs[24] = mk("sz11_done", Y, N, 2'b11, N, Y, 32'h0000_0048, 32'h0,       N, 32'h0,          N, N, N, 32'h0,        4'b0000, 32'h0,        Y, 32'h1234_5678, N, N);
    vecs[25] = mk("rdwr_req",  Y, Y, 2'b10, N, N, 32'h0000_0080, 32'h1122_3344, Y, 32'h5555_5555, Y, Y, Y, 32'h80,      4'b1111, 32'h1122_3344, N, 32'h0,        N, N);
    vecs[26] = mk("rdwr_done", Y, Y, 2'b10, N, N, 32'h0000_0080, 32'h1122_3344, N, 32'h0,        N, N, N, 32'h0,        4'b0000, 32'h0,        N, 32'h0,        N, N);
    vecs[27] = mk("idle_ack",  N, N, 2'b00, N, Y, 32'h0000_0010, 32'h0,       Y, 32'hFFFF_FFFF,  N, N, N, 32'h0,        4'b0000, 32'h0,        Y, 32'h0,        N, N);
    vecs[28] = mk("idle_ack2", N, N, 2'b00, N, Y, 32'h0000_0014, 32'h0,       N, 32'h0,          N, N, N, 32'h0,        4'b0000, 32'h0,        Y, 32'h0,        N, N);
    vecs[29] = mk("to_c1",     Y, N, 2'b10, N, Y, 32'h0000_0040, 32'h0,       N, 32'h0,          Y, Y, N, 32'h40,       4'b1111, 32'h0,        N, 32'h0,        N, N);
    vecs[30] = mk("to_c2",     Y, N, 2'b10, N, Y, 32'h0000_0040, 32'h0,       N, 32'h0,          Y, Y, N, 32'h40,       4'b1111, 32'h0,        N, 32'h0,        N, N);
    vecs[31] = mk("to_c3",     Y, N, 2'b10, N, Y, 32'h0000_0040, 32'h0,       N, 32'h0,          Y, Y, N, 32'h40,       4'b1111, 32'h0,        N, 32'h0,        N, N);
    vecs[32] = mk("to_c4",     Y, N, 2'b10, N, Y, 32'h0000_0040, 32'h0,       N, 32'h0,          Y, Y, N, 32'h40,       4'b1111, 32'h0,        N, 32'h0,        N, N);
    vecs[33] = mk("to_done",   Y, N, 2'b10, N, Y, 32'h0000_0040, 32'h0,       N, 32'h0,          N, N, N, 32'h0,        4'b0000, 32'h0,        N, 32'h0,        N, Y);
    vecs[34] = mk("to_next",   N, N, 2'b00, N, Y, 32'h0000_0020, 32'h0,       N, 32'h0,          N, N, N, 32'h0,        4'b0000, 32'h0,        Y, 32'h0,        N, N);

    // Reset state: a live load request on the inputs must not leak out.
    Rst = 1'b0;
    apply(vecs[29]);
    #12;
    chk("rst.req", 32'(DM_Req), 32'd0);
    chk("rst.stall", 32'(Stall), 32'd0);
    chk("rst.regwrite", 32'(RegWrite_Out), 32'd0);
    chk("rst.alu_out", ALU_Result_Out, 32'd0);
    chk("rst.pc_out", PC_AddResult_Out, 32'd0);
    chk("rst.rd_out", 32'(Rd_Out), 32'd0);
    chk("rst.misalign", 32'(MisalignErr), 32'd0);
    apply(vecs[2]);
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      exp_q.push_back(vecs[i]);
      #4;
      e = exp_q.pop_front();
      compare_row(e);
      @(posedge Clk); #1;
    end

    // Reset in the middle of an outstanding load, then a stray ack after release.
    apply(vecs[29]);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    #2;
    chk("midrst.req_before", 32'(DM_Req), 32'd1);
    Rst = 1'b0;
    #1;
    chk("midrst.req", 32'(DM_Req), 32'd0);
    chk("midrst.stall", 32'(Stall), 32'd0);
    chk("midrst.regwrite", 32'(RegWrite_Out), 32'd0);
    apply(vecs[2]);
    @(posedge Clk); #1;
    Rst = 1'b1;
    DM_Ack = 1'b1;
    DM_RData = 32'hFFFF_FFFF;
    #3;
    chk("postrst.ack_stall", 32'(Stall), 32'd0);
    chk("postrst.ack_req", 32'(DM_Req), 32'd0);
    chk("postrst.ack_regwrite", 32'(RegWrite_Out), 32'd0);
    @(posedge Clk); #1;
    DM_Ack = 1'b0;
    #3;
    chk("postrst.stall", 32'(Stall), 32'd0);
    chk("postrst.buserr", 32'(BusErr), 32'd0);
    chk("postrst.regwrite", 32'(RegWrite_Out), 32'd0);
    chk("postrst.rdata_out", DM_ReadData_Out, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name:
mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline, between the EX/MEM register and the MEM/WB register.
- Performs loads and stores against a variable-latency data memory using a req/ack handshake.
- Handles byte/half/word lane alignment with sign or zero extension, stalls upstream while an access is outstanding, and presents writeback controls and data directly to the MEM/WB register inputs.

Parameters:
TIMEOUT_CYCLES, 16, number of DM_Req-high cycles without DM_Ack before the access aborts; 0 disables the timeout.

Ports:
Clk  input  1  pipeline clock, rising edge
Rst  input  1  asynchronous, active-low reset
MemRead_In  input  1  load instruction in MEM
MemWrite_In  input  1  store instruction in MEM
MemSize_In  input  2  00 byte, 01 half, 10 word, 11 treated as word
MemSigned_In  input  1  1 = sign-extend load, 0 = zero-extend
RegWrite_In  input  1  writeback enable from EX/MEM
MemToReg_In  input  1  writeback mux select from EX/MEM
ALU_Result_In  input  32  effective address or ALU result
WriteData_In  input  32  store data (rt)
PC_AddResult_In  input  32  PC+4 passthrough
EX_MEM_Rd_In  input  5  destination register
DM_Req  output  1  memory request
DM_We  output  1  1 = write
DM_Addr  output  32  word address, ALU_Result_In with bits [1:0] forced to 0
DM_BE  output  4  byte enables, bit i = byte lane i (little-endian)
DM_WData  output  32  lane-replicated store data
DM_RData  input  32  read word, valid when DM_Ack=1
DM_Ack  input  1  access complete
Stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
RegWrite_Out  output  1  to MEM/WB
MemToReg_Out  output  1  to MEM/WB
DM_ReadData_Out  output  32  aligned, extended load data to MEM/WB
ALU_Result_Out  output  32  to MEM/WB
PC_AddResult_Out  output  32  to MEM/WB
Rd_Out  output  5  to MEM/WB
MisalignErr  output  1  one-cycle pulse on a misaligned access
BusErr  output  1  one-cycle pulse on timeout abort

Behaviour:
- **FSM states:** IDLE, WAIT, DONE. State is registered; all other outputs are combinational from state, inputs and the capture register.
- **While Rst is low:** state=IDLE, timeout counter=0, captured data=0, every output 0. Reset asserted mid-WAIT drops DM_Req immediately; an ack arriving after reset release is ignored.
- **Memory op definition:** MemRead_In|MemWrite_In. If both are set, it is treated as a store.
- **Misaligned access:** half with Addr[0]=1, or word with Addr[1:0]!=0. No request is issued; MisalignErr=1 for that cycle; RegWrite_Out=0; Stall=0; state stays IDLE.
- **IDLE, aligned memory op:**
  - DM_Req=1 and Stall=1.
  - DM_Ack=1 goes to DONE and captures the data; otherwise goes to WAIT.
- **IDLE, non-memory op:** zero-latency passthrough, Stall=0, DM_Req=0.
- **WAIT:**
  - DM_Req=1, Stall=1; address, BE and data held stable (inputs are frozen by Stall).
  - Counter increments each cycle.
  - DM_Ack moves to DONE.
  - Counter reaching TIMEOUT_CYCLES-1 without ack moves to DONE with the abort flag set.
- **DONE:**
  - DM_Req=0, Stall=0, outputs valid, then unconditionally back to IDLE; the counter is cleared.
  - If the abort flag is set: BusErr=1 and RegWrite_Out=0.
  - DM_Ack in DONE or IDLE without a request is ignored.
- **Minimum latency:** every memory op costs at least one stall cycle (ack in the request cycle gives exactly one).
- **Store lanes:**
  - byte: BE = 0001 << Addr[1:0], WData = byte replicated x4
  - half: BE = 0011 << Addr[1:0], WData = half replicated x2
  - word: BE = 1111
  - loads: DM_We=0 and BE = the same mask.
- **Load extract:** lane selected by Addr[1:0], then extended per MemSigned_In. Only the DONE value is meaningful; the output is 0 otherwise.
- **Passthrough:** RegWrite, MemToReg, ALU_Result, PC_AddResult and Rd pass through. RegWrite_Out is forced 0 whenever Stall=1, so a bubble enters MEM/WB.

Decomposition:
- Package mem_stage_pkg: MemSize encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encodings.
- One sub-module, mem_load_align: combinational lane select and extension, also reused by the store BE/replication logic.

Test Plan:
- **ALU passthrough:** RegWrite=1, Rd=5, ALU=0x0000_1234, no mem op -> Stall=0, DM_Req=0, RegWrite_Out=1, Rd_Out=5, ALU_Result_Out=0x1234 in the same cycle.
- **lb signed, delayed ack:** addr 0x103, ack on the 3rd request cycle with DM_RData=0x80FF_FF7F -> DM_Addr=0x100, BE=1000, Stall=1 for 3 cycles, DONE gives DM_ReadData_Out=0xFFFF_FF80 and RegWrite_Out=1; same sequence with lbu -> 0x0000_0080.
- **sh, same-cycle ack:** addr 0x202, WriteData=0xAAAA_BEEF, ack in the request cycle -> DM_We=1, BE=1100, WData=0xBEEF_BEEF, exactly one stall cycle.
- **Misaligned lw:** addr 0x101 -> MisalignErr pulses once, DM_Req never rises, Stall=0, RegWrite_Out=0.
- **Timeout:** TIMEOUT_CYCLES=4, lw at 0x40, DM_Ack held 0 -> Stall=1 for 4 cycles, then one DONE cycle with BusErr=1, RegWrite_Out=0, then IDLE.
- **Reset mid-access:** Rst low during WAIT -> DM_Req and Stall drop asynchronously; DM_Ack=1 after release produces no DONE and no RegWrite_Out.
